// File: rtl/amux_scan_pkg.sv
// Shared definitions for the analog-mux scan sequencer: command codes, state encodings,
// status bit positions and channel-search helpers.
package amux_scan_pkg;

  localparam logic [7:0] CmdMask   = 8'h01;
  localparam logic [7:0] CmdDwell  = 8'h02;
  localparam logic [7:0] CmdStart  = 8'h03;
  localparam logic [7:0] CmdStop   = 8'h04;
  localparam logic [7:0] CmdClrErr = 8'h05;

  typedef enum logic [1:0] {
    ScanIdle = 2'd0,
    ScanGap  = 2'd1,
    ScanOn   = 2'd2
  } scan_state_e;

  typedef enum logic {
    ParseCmd  = 1'b0,
    ParseData = 1'b1
  } parse_state_e;

  localparam int unsigned StatusBusyBit = 7;
  localparam int unsigned StatusErrBit  = 6;
  localparam int unsigned StatusContBit = 5;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Returns {found, index} of the lowest set bit strictly above cur.
  function automatic logic [3:0] next_set_above(input logic [7:0] m, input logic [2:0] cur);
    logic [3:0] res;
    res = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/amux_scan_cmd.sv
// Two-byte frame parser: command byte then data byte, emitting a one-cycle cmd_valid.
module amux_scan_cmd
  import amux_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst_neg,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       cmd_valid,
  output logic [7:0] cmd,
  output logic [7:0] data
);

  parse_state_e state;

  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      state     <= ParseCmd;
      cmd_valid <= 1'b0;
      cmd       <= '0;
      data      <= '0;
    end else begin
      cmd_valid <= 1'b0;
      if (byte_valid) begin
        if (state == ParseCmd) begin
          cmd   <= byte_in;
          state <= ParseData;
        end else begin
          data      <= byte_in;
          cmd_valid <= 1'b1;
          state     <= ParseCmd;
        end
      end
    end
  end

endmodule

// File: rtl/amux_scan_seq.sv
// Break-before-make analog-mux scan sequencer controlled by 2-byte SPI command frames.
module amux_scan_seq
  import amux_scan_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_neg,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic [7:0] amux_en,
  output logic [7:0] amux_en_neg,
  output logic       scan_busy,
  output logic [7:0] status
);

  logic        cmd_valid;
  logic [7:0]  cmd;
  logic [7:0]  data;

  scan_state_e state;
  logic [7:0]  mask;
  logic [7:0]  dwell;
  logic        cont;
  logic        err;
  logic [2:0]  ch_idx;
  logic [7:0]  cnt;
  logic [3:0]  nxt;

  amux_scan_cmd u_cmd (
    .clk        (clk),
    .rst_neg    (rst_neg),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .data       (data)
  );

  assign nxt         = next_set_above(mask, ch_idx);
  assign scan_busy   = (state != ScanIdle);
  assign amux_en_neg = ~amux_en;

  always_comb begin
    status                = '0;
    status[StatusBusyBit] = scan_busy;
    status[StatusErrBit]  = err;
    status[StatusContBit] = cont;
    status[2:0]           = ch_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      state   <= ScanIdle;
      mask    <= '0;
      dwell   <= '0;
      cont    <= 1'b0;
      err     <= 1'b0;
      ch_idx  <= '0;
      cnt     <= '0;
      amux_en <= '0;
    end else begin
      case (state)
        ScanIdle: ;
        ScanGap: begin
          if (cnt == 8'(GAP_CYCLES - 1)) begin
            state   <= ScanOn;
            cnt     <= '0;
            amux_en <= 8'h01 << ch_idx;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ScanOn: begin
          if (cnt == dwell) begin
            amux_en <= '0;
            cnt     <= '0;
            if (nxt[3]) begin
              ch_idx <= nxt[2:0];
              state  <= ScanGap;
            end else if (cont) begin
              ch_idx <= lowest_set(mask);
              state  <= ScanGap;
            end else begin
              state <= ScanIdle;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= ScanIdle;
      endcase

      // Commands are applied after the scan step so STOP/START take priority over it.
      if (cmd_valid) begin
        case (cmd)
          CmdMask: begin
            if (scan_busy) err <= 1'b1;
            else           mask <= data;
          end
          CmdDwell: begin
            if (scan_busy) err <= 1'b1;
            else           dwell <= data;
          end
          CmdStart: begin
            if (scan_busy || (mask == 8'h00)) begin
              err <= 1'b1;
            end else begin
              state   <= ScanGap;
              cnt     <= '0;
              cont    <= data[0];
              ch_idx  <= lowest_set(mask);
              amux_en <= '0;
            end
          end
          CmdStop: begin
            state   <= ScanIdle;
            cnt     <= '0;
            amux_en <= '0;
          end
          CmdClrErr: err <= 1'b0;
          default:   err <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_amux_scan_seq.sv
// Self-checking bench for amux_scan_seq: scan sequences are predicted into a queue and
// popped cycle by cycle against the DUT.
module tb_amux_scan_seq;
  import amux_scan_pkg::*;

  logic       clk = 1'b0;
  logic       rst_neg = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = '0;
  logic [7:0] amux_en;
  logic [7:0] amux_en_neg;
  logic       scan_busy;
  logic [7:0] status;

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  amux_scan_seq #(.GAP_CYCLES(2)) dut (
    .clk         (clk),
    .rst_neg     (rst_neg),
    .byte_valid  (byte_valid),
    .byte_in     (byte_in),
    .amux_en     (amux_en),
    .amux_en_neg (amux_en_neg),
    .scan_busy   (scan_busy),
    .status      (status)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in    = b;
    step();
    byte_valid = 1'b0;
  endtask

  // Sends a frame and returns just after the edge that applies it.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] d);
    send_byte(c);
    send_byte(d);
    step();
  endtask

  task automatic do_reset();
    rst_neg = 1'b0;
    step();
    rst_neg = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (amux_en !== 8'h00) $display("FAIL reset_en: got %h expected 00", amux_en);
    else passed++;
    checks++;
    if (amux_en_neg !== 8'hFF) $display("FAIL reset_en_neg: got %h expected ff", amux_en_neg);
    else passed++;
    checks++;
    if (status !== 8'h00 || scan_busy !== 1'b0)
      $display("FAIL reset_status: got %h/%b expected 00/0", status, scan_busy);
    else passed++;
  endtask

  task automatic test_single_scan();
    send_frame(CmdMask, 8'h05);
    send_frame(CmdDwell, 8'h03);
    send_frame(CmdStart, 8'h00);
    checks++;
    if (scan_busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", scan_busy);
    else passed++;
    exp_q = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01,
              8'h00, 8'h00, 8'h04, 8'h04, 8'h04, 8'h04};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (amux_en !== e || amux_en_neg !== ~e)
        $display("FAIL single_seq: got %h/%h expected %h/%h", amux_en, amux_en_neg, e, ~e);
      else passed++;
      step();
    end
    checks++;
    if (status !== 8'h02 || amux_en !== 8'h00)
      $display("FAIL single_end: got status %h en %h expected 02 00", status, amux_en);
    else passed++;
  endtask

  task automatic test_wrap_stop();
    send_frame(CmdMask, 8'h81);
    send_frame(CmdDwell, 8'h00);
    send_frame(CmdStart, 8'h01);
    exp_q = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h80,
              8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h80};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (amux_en !== e) $display("FAIL wrap_seq: got %h expected %h", amux_en, e);
      else passed++;
      step();
    end
    send_frame(CmdStop, 8'h00);
    checks++;
    if (amux_en !== 8'h00 || scan_busy !== 1'b0)
      $display("FAIL stop: got en %h busy %b expected 00 0", amux_en, scan_busy);
    else passed++;
    checks++;
    if (status[StatusContBit] !== 1'b1 || status[7:6] !== 2'b00)
      $display("FAIL stop_status: got %h expected cont=1 busy=0 err=0", status);
    else passed++;
  endtask

  task automatic test_mask_zero();
    do_reset();
    send_frame(CmdMask, 8'h00);
    send_frame(CmdStart, 8'h00);
    step();
    checks++;
    if (scan_busy !== 1'b0 || status !== 8'h40)
      $display("FAIL mask_zero: got busy %b status %h expected 0 40", scan_busy, status);
    else passed++;
    send_frame(CmdClrErr, 8'h00);
    checks++;
    if (status !== 8'h00) $display("FAIL clrerr: got %h expected 00", status);
    else passed++;
  endtask

  task automatic test_busy_errors();
    logic [7:0] stim [4];
    stim = '{CmdMask, 8'hFF, CmdStart, 8'h01};
    send_frame(CmdMask, 8'h05);
    send_frame(CmdDwell, 8'h01);
    send_frame(CmdStart, 8'h00);
    exp_q = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h04, 8'h04};
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (amux_en !== e) $display("FAIL busy_seq[%0d]: got %h expected %h", i, amux_en, e);
      else passed++;
      byte_valid = (i < 4);
      byte_in    = (i < 4) ? stim[i] : 8'h00;
      step();
      byte_valid = 1'b0;
    end
    checks++;
    if (scan_busy !== 1'b0 || status !== 8'h42)
      $display("FAIL busy_err: got busy %b status %h expected 0 42", scan_busy, status);
    else passed++;
    send_frame(CmdClrErr, 8'h00);
    send_frame(8'h7E, 8'h05);
    checks++;
    if (status !== 8'h42) $display("FAIL unknown_cmd: got %h expected 42", status);
    else passed++;
    send_frame(CmdClrErr, 8'h00);
    checks++;
    if (status !== 8'h02) $display("FAIL post_unknown: got %h expected 02", status);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_frame(CmdMask, 8'h10);
    send_frame(CmdDwell, 8'h0A);
    send_frame(CmdStart, 8'h00);
    exp_q = '{8'h00, 8'h00, 8'h10};
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (amux_en !== e) $display("FAIL mid_seq[%0d]: got %h expected %h", i, amux_en, e);
      else passed++;
      if (i < 2) step();
    end
    do_reset();
    checks++;
    if (amux_en !== 8'h00 || amux_en_neg !== 8'hFF || status !== 8'h00)
      $display("FAIL mid_reset: got %h/%h/%h expected 00/ff/00", amux_en, amux_en_neg, status);
    else passed++;
    send_byte(CmdMask);
    do_reset();
    send_frame(CmdMask, 8'h08);
    send_frame(CmdStart, 8'h00);
    exp_q = '{8'h00, 8'h00, 8'h08};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (amux_en !== e) $display("FAIL half_frame_seq: got %h expected %h", amux_en, e);
      else passed++;
      if (exp_q.size() > 0) step();
    end
    checks++;
    if (status !== 8'h83) $display("FAIL half_frame_status: got %h expected 83", status);
    else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    test_single_scan();
    test_wrap_stop();
    test_mask_zero();
    test_busy_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
